// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle control FSM.
//   state_t  - 12 FSM states in a 4-bit encoding (FETCH = 0, the reset state)
//   OP_*     - supported opcodes (inst[WIDTH-1:WIDTH-6])
//   FN_*     - supported R-type funct codes (inst[5:0])
//   ALU_*    - alucont codes driven to the ALU
//   aluop_t  - request class handed to alu_decoder
//   SRCB_*   - alusrcb mux selects (010 raw inst is reserved by the datapath)
//   PCSRC_*  - pcsource mux selects (11 is tied to zero in the datapath)
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] SRCB_REGB     = 3'b000;
    localparam logic [2:0] SRCB_FOUR     = 3'b001;
    localparam logic [2:0] SRCB_INST_SL2 = 3'b011;
    localparam logic [2:0] SRCB_SEXT     = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Memory-class opcodes share the address-generation state.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational ALU control.
//   aluop   in  request class: fixed add, fixed sub, or decode funct
//   funct   in  inst[5:0]
//   alucont out ALU operation code
//   valid   out 1 when the request is supported (funct known in funct mode)
module alu_decoder
    import ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucont,
    output logic        valid
);

    always_comb begin
        alucont = ALU_ADD;
        valid   = 1'b1;
        case (aluop)
            ALUOP_ADD: alucont = ALU_ADD;
            ALUOP_SUB: alucont = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucont = ALU_ADD;
                    FN_SUB:  alucont = ALU_SUB;
                    FN_AND:  alucont = ALU_AND;
                    FN_OR:   alucont = ALU_OR;
                    FN_SLT:  alucont = ALU_SLT;
                    default: valid   = 1'b0;
                endcase
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: control FSM for the multicycle datapath.
//   clk, rst      clock, synchronous active-low reset
//   inst_i        latched instruction (opcode in top 6 bits, funct in [5:0])
//   zero_i        ALU result is zero (branch decision)
//   mem_ready_i   memory completes the current request this cycle
//   alusrca_o/alusrcb_o/alucont_o/pcsource_o   datapath mux and ALU selects
//   pcen_o/irwrite_o/regwrite_o                write enables
//   iord_o/regdst_o/memtoreg_o                 address / register selects
//   memreq_o/memwrite_o                        memory request handshake
//   illegal_o     one-cycle pulse in DECODE on an unsupported instruction
//   state_o       current state, debug only
// Several outputs follow inputs within the same cycle (irwrite/pcen on ready,
// pcen on zero, illegal on decode), so outputs are decoded from the state
// register rather than registered.
module mc_control
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inst_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             alusrca_o,
    output logic [2:0]       alusrcb_o,
    output logic [2:0]       alucont_o,
    output logic [1:0]       pcsource_o,
    output logic             pcen_o,
    output logic             irwrite_o,
    output logic             iord_o,
    output logic             regdst_o,
    output logic             memtoreg_o,
    output logic             regwrite_o,
    output logic             memreq_o,
    output logic             memwrite_o,
    output logic             illegal_o,
    output logic [3:0]       state_o
);

    state_t      state;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    aluop_t      aluop;
    logic [2:0]  dec_alucont;
    logic        funct_ok;
    logic        dec_illegal;
    logic        unused_inst;

    assign opcode      = inst_i[WIDTH-1 -: 6];
    assign funct       = inst_i[5:0];
    assign unused_inst = ^inst_i[WIDTH-7:6];

    // DECODE runs the decoder in funct mode purely for its valid flag;
    // the ALU itself still adds there (branch target precompute).
    always_comb begin
        case (state)
            S_DECODE, S_RTYPEEX: aluop = ALUOP_FUNCT;
            S_BEQEX:             aluop = ALUOP_SUB;
            default:             aluop = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_dec (
        .aluop   (aluop),
        .funct   (funct),
        .alucont (dec_alucont),
        .valid   (funct_ok)
    );

    always_comb begin
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: dec_illegal = 1'b0;
            OP_RTYPE:                           dec_illegal = !funct_ok;
            default:                            dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (mem_ready_i) state <= S_DECODE;
                S_DECODE: begin
                    if (dec_illegal)
                        state <= S_FETCH;
                    else if (is_mem_op(opcode))
                        state <= S_MEMADR;
                    else begin
                        case (opcode)
                            OP_RTYPE: state <= S_RTYPEEX;
                            OP_BEQ:   state <= S_BEQEX;
                            OP_ADDI:  state <= S_ADDIEX;
                            OP_J:     state <= S_JEX;
                            default:  state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:  state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready_i) state <= S_MEMWB;
                S_MEMWR:   if (mem_ready_i) state <= S_FETCH;
                S_RTYPEEX: state <= S_RTYPEWB;
                S_ADDIEX:  state <= S_ADDIWB;
                default:   state <= S_FETCH;  // MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX
            endcase
        end
    end

    // Everything defaults low; reset forces all outputs low so a request
    // in flight is dropped without a write.
    always_comb begin
        alusrca_o  = 1'b0;
        alusrcb_o  = SRCB_REGB;
        alucont_o  = ALU_AND;
        pcsource_o = PCSRC_ALU;
        pcen_o     = 1'b0;
        irwrite_o  = 1'b0;
        iord_o     = 1'b0;
        regdst_o   = 1'b0;
        memtoreg_o = 1'b0;
        regwrite_o = 1'b0;
        memreq_o   = 1'b0;
        memwrite_o = 1'b0;
        illegal_o  = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    memreq_o  = 1'b1;
                    alusrcb_o = SRCB_FOUR;
                    alucont_o = ALU_ADD;
                    irwrite_o = mem_ready_i;
                    pcen_o    = mem_ready_i;
                end
                S_DECODE: begin
                    alusrcb_o = SRCB_INST_SL2;
                    alucont_o = ALU_ADD;
                    illegal_o = dec_illegal;
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca_o = 1'b1;
                    alusrcb_o = SRCB_SEXT;
                    alucont_o = ALU_ADD;
                end
                S_MEMRD: begin
                    memreq_o = 1'b1;
                    iord_o   = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg_o = 1'b1;
                    regwrite_o = 1'b1;
                end
                S_MEMWR: begin
                    memreq_o   = 1'b1;
                    memwrite_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca_o = 1'b1;
                    alucont_o = dec_alucont;
                end
                S_RTYPEWB: begin
                    regdst_o   = 1'b1;
                    regwrite_o = 1'b1;
                end
                S_BEQEX: begin
                    alusrca_o  = 1'b1;
                    alucont_o  = dec_alucont;
                    pcsource_o = PCSRC_ALUOUT;
                    pcen_o     = zero_i;
                end
                S_ADDIWB: regwrite_o = 1'b1;
                S_JEX: begin
                    pcsource_o = PCSRC_JUMP;
                    pcen_o     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_o = rst ? 4'(state) : 4'd0;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        alusrca_o;
    logic [2:0]  alusrcb_o;
    logic [2:0]  alucont_o;
    logic [1:0]  pcsource_o;
    logic        pcen_o, irwrite_o, iord_o, regdst_o, memtoreg_o;
    logic        regwrite_o, memreq_o, memwrite_o, illegal_o;
    logic [3:0]  state_o;
    logic [17:0] obs;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_control #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o),
        .alucont_o(alucont_o), .pcsource_o(pcsource_o), .pcen_o(pcen_o),
        .irwrite_o(irwrite_o), .iord_o(iord_o), .regdst_o(regdst_o),
        .memtoreg_o(memtoreg_o), .regwrite_o(regwrite_o), .memreq_o(memreq_o),
        .memwrite_o(memwrite_o), .illegal_o(illegal_o), .state_o(state_o)
    );

    assign obs = {alusrca_o, alusrcb_o, alucont_o, pcsource_o, pcen_o, irwrite_o,
                  iord_o, regdst_o, memtoreg_o, regwrite_o, memreq_o, memwrite_o,
                  illegal_o};

    // Expected control word, fields in the same order as obs.
    function automatic logic [17:0] f(input int srca, input int srcb, input int acont,
                                      input int psrc, input int pcen, input int irw,
                                      input int iord, input int rdst, input int m2r,
                                      input int rw, input int mreq, input int mw,
                                      input int ill);
        return {srca[0], srcb[2:0], acont[2:0], psrc[1:0], pcen[0], irw[0], iord[0],
                rdst[0], m2r[0], rw[0], mreq[0], mw[0], ill[0]};
    endfunction

    //                                 sa sb ac ps pe ir io rd mr rw mq mw il
    localparam logic [17:0] E_FETCH_W = f(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    localparam logic [17:0] E_FETCH_R = f(0, 1, 2, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    localparam logic [17:0] E_DECODE  = f(0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [17:0] E_DEC_ILL = f(0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    localparam logic [17:0] E_MEMADR  = f(1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [17:0] E_MEMRD   = f(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    localparam logic [17:0] E_MEMWB   = f(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    localparam logic [17:0] E_MEMWR   = f(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    localparam logic [17:0] E_RADD    = f(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [17:0] E_RSLT    = f(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [17:0] E_RWB     = f(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    localparam logic [17:0] E_BEQ1    = f(1, 0, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [17:0] E_BEQ0    = f(1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [17:0] E_ADDI    = f(1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    localparam logic [17:0] E_AWB     = f(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    localparam logic [17:0] E_JEX     = f(0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive handshake inputs, check state and controls,
    // then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic rdy, input logic z,
                       input int st, input logic [17:0] ctl);
        mem_ready_i = rdy;
        zero_i      = z;
        #1;
        chk({tag, "/st"}, 32'(state_o), 32'(st));
        chk({tag, "/ctl"}, 32'(obs), 32'(ctl));
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst         = 1'b0;
        inst_i      = 32'h8C43_0004;
        zero_i      = 1'b1;
        mem_ready_i = 1'b1;

        // Reset: outputs gated low even with ready/zero high
        repeat (3) @(posedge clk);
        #3;
        chk("rst/ctl", 32'(obs), 32'd0);
        chk("rst/st", 32'(state_o), 32'd0);
        rst = 1'b1;

        // lw, 2 wait cycles in FETCH, 1 in MEMRD: 8 cycles total
        cyc("lw_f1", 0, 0, 0, E_FETCH_W);
        cyc("lw_f2", 0, 0, 0, E_FETCH_W);
        cyc("lw_f3", 1, 0, 0, E_FETCH_R);
        cyc("lw_dec", 0, 0, 1, E_DECODE);
        cyc("lw_adr", 0, 0, 2, E_MEMADR);
        cyc("lw_rd1", 0, 0, 3, E_MEMRD);
        cyc("lw_rd2", 1, 0, 3, E_MEMRD);
        cyc("lw_wb", 0, 0, 4, E_MEMWB);

        inst_i = 32'hAC43_0008;  // sw
        cyc("sw_f", 1, 0, 0, E_FETCH_R);
        cyc("sw_dec", 0, 0, 1, E_DECODE);
        cyc("sw_adr", 0, 0, 2, E_MEMADR);
        cyc("sw_wr", 1, 0, 5, E_MEMWR);

        inst_i = 32'h0062_1020;  // add
        cyc("add_f", 1, 0, 0, E_FETCH_R);
        cyc("add_dec", 0, 0, 1, E_DECODE);
        cyc("add_ex", 0, 0, 6, E_RADD);
        cyc("add_wb", 0, 0, 7, E_RWB);

        inst_i = 32'h0062_102A;  // slt
        cyc("slt_f", 1, 0, 0, E_FETCH_R);
        cyc("slt_dec", 0, 0, 1, E_DECODE);
        cyc("slt_ex", 0, 0, 6, E_RSLT);
        cyc("slt_wb", 0, 0, 7, E_RWB);

        inst_i = 32'h1043_0002;  // beq taken
        cyc("beq1_f", 1, 0, 0, E_FETCH_R);
        cyc("beq1_dec", 0, 0, 1, E_DECODE);
        cyc("beq1_ex", 0, 1, 8, E_BEQ1);
        cyc("beq0_f", 1, 0, 0, E_FETCH_R);  // same beq, not taken
        cyc("beq0_dec", 0, 0, 1, E_DECODE);
        cyc("beq0_ex", 0, 0, 8, E_BEQ0);

        inst_i = 32'h2043_0005;  // addi
        cyc("addi_f", 1, 0, 0, E_FETCH_R);
        cyc("addi_dec", 0, 0, 1, E_DECODE);
        cyc("addi_ex", 0, 0, 9, E_ADDI);
        cyc("addi_wb", 0, 0, 10, E_AWB);

        inst_i = 32'h0800_0010;  // j
        cyc("j_f", 1, 0, 0, E_FETCH_R);
        cyc("j_dec", 0, 0, 1, E_DECODE);
        cyc("j_ex", 0, 0, 11, E_JEX);

        inst_i = 32'hFC00_0000;  // opcode 0x3F
        cyc("ilop_f", 1, 0, 0, E_FETCH_R);
        cyc("ilop_dec", 0, 0, 1, E_DEC_ILL);

        inst_i = 32'h0000_003F;  // opcode 0, funct 0x3F
        cyc("ilfn_f", 1, 0, 0, E_FETCH_R);
        cyc("ilfn_dec", 0, 0, 1, E_DEC_ILL);

        // Reset while a load waits in MEMRD
        inst_i = 32'h8C43_0004;
        cyc("rmid_f", 1, 0, 0, E_FETCH_R);
        cyc("rmid_dec", 0, 0, 1, E_DECODE);
        cyc("rmid_adr", 0, 0, 2, E_MEMADR);
        cyc("rmid_rd", 0, 0, 3, E_MEMRD);
        rst         = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        chk("rmid_rst/ctl", 32'(obs), 32'd0);
        chk("rmid_rst/st", 32'(state_o), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc("rmid_after", 0, 0, 0, E_FETCH_W);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
